// File: rtl/hilo_muldiv.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply, restoring divide,
// one result bit per cycle, plus MTHI/MTLO/MFHI/MFLO register moves.
module hilo_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rdata,
  output logic             div0,
  output logic             illegal
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_MADD  = 6'b011100;
  localparam logic [5:0] OP_MADDU = 6'b011101;
  localparam logic [5:0] OP_DIV   = 6'b011010;
  localparam logic [5:0] OP_DIVU  = 6'b011011;
  localparam logic [5:0] OP_MTHI  = 6'b010001;
  localparam logic [5:0] OP_MTLO  = 6'b010011;
  localparam logic [5:0] OP_MFHI  = 6'b010000;
  localparam logic [5:0] OP_MFLO  = 6'b010010;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t r_state, w_next;

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi, r_lo, r_rdata;
  logic [WIDTH-1:0] r_acc, r_shr, r_m;
  logic             r_isdiv, r_madd, r_neg, r_rneg;
  logic             r_div0, r_illegal;

  logic             w_accept, w_is_mul, w_is_div, w_signed, w_is_madd, w_legal, w_div0;
  logic [WIDTH-1:0] w_abs_a, w_abs_b;
  logic [WIDTH:0]   w_sum, w_sh, w_sub;
  logic             w_ge;
  logic [2*WIDTH-1:0] w_prod, w_mres;
  logic [WIDTH-1:0] w_quo, w_rem;

  always_comb begin
    w_is_mul  = 1'b0;
    w_is_div  = 1'b0;
    w_signed  = 1'b0;
    w_is_madd = 1'b0;
    w_legal   = 1'b1;
    case (op)
      OP_MULT:  begin w_is_mul = 1'b1; w_signed = 1'b1; end
      OP_MULTU: w_is_mul = 1'b1;
      OP_MADD:  begin w_is_mul = 1'b1; w_signed = 1'b1; w_is_madd = 1'b1; end
      OP_MADDU: begin w_is_mul = 1'b1; w_is_madd = 1'b1; end
      OP_DIV:   begin w_is_div = 1'b1; w_signed = 1'b1; end
      OP_DIVU:  w_is_div = 1'b1;
      OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO: ;
      default:  w_legal = 1'b0;
    endcase
  end

  assign w_accept = start && (r_state == IDLE);
  assign w_div0   = w_is_div && (b == '0);
  assign w_abs_a  = (w_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign w_abs_b  = (w_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

  // Multiply step: conditional add into the upper half, then shift the pair right.
  assign w_sum = {1'b0, r_acc} + (r_shr[0] ? {1'b0, r_m} : '0);
  // Divide step: partial remainder gains the next dividend bit from r_shr's MSB.
  assign w_sh  = {r_acc, r_shr[WIDTH-1]};
  assign w_ge  = (w_sh >= {1'b0, r_m});
  assign w_sub = w_sh - {1'b0, r_m};

  assign w_prod = r_neg ? (~{r_acc, r_shr} + 1'b1) : {r_acc, r_shr};
  assign w_mres = r_madd ? ({r_hi, r_lo} + w_prod) : w_prod;
  assign w_quo  = r_neg  ? (~r_shr + 1'b1) : r_shr;
  assign w_rem  = r_rneg ? (~r_acc + 1'b1) : r_acc;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) begin
        if (w_is_mul || (w_is_div && !w_div0)) w_next = CALC;
        else if (w_legal)                      w_next = DONE;
      end
      CALC: if (r_cnt == CW'(WIDTH - 1)) w_next = FIX;
      FIX:  w_next = DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_rdata   <= '0;
      r_acc     <= '0;
      r_shr     <= '0;
      r_m       <= '0;
      r_isdiv   <= 1'b0;
      r_madd    <= 1'b0;
      r_neg     <= 1'b0;
      r_rneg    <= 1'b0;
      r_div0    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_div0    <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        IDLE: if (w_accept) begin
          r_cnt <= '0;
          r_acc <= '0;
          if (w_is_mul) begin
            r_m     <= w_abs_a;
            r_shr   <= w_abs_b;
            r_neg   <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            r_rneg  <= 1'b0;
            r_madd  <= w_is_madd;
            r_isdiv <= 1'b0;
          end else if (w_is_div && !w_div0) begin
            r_m     <= w_abs_b;
            r_shr   <= w_abs_a;
            r_neg   <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            r_rneg  <= w_signed && a[WIDTH-1];
            r_madd  <= 1'b0;
            r_isdiv <= 1'b1;
          end else if (w_div0) begin
            r_hi   <= a;
            r_lo   <= '1;
            r_div0 <= 1'b1;
          end else begin
            case (op)
              OP_MTHI: r_hi    <= a;
              OP_MTLO: r_lo    <= a;
              OP_MFHI: r_rdata <= r_hi;
              OP_MFLO: r_rdata <= r_lo;
              default: r_illegal <= 1'b1;
            endcase
          end
        end
        CALC: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_isdiv) begin
            r_acc <= w_ge ? w_sub[WIDTH-1:0] : w_sh[WIDTH-1:0];
            r_shr <= {r_shr[WIDTH-2:0], w_ge};
          end else begin
            r_acc <= w_sum[WIDTH:1];
            r_shr <= {w_sum[0], r_shr[WIDTH-1:1]};
          end
        end
        FIX: begin
          if (r_isdiv) begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end else begin
            {r_hi, r_lo} <= w_mres;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = (r_state != IDLE);
  assign done    = (r_state == DONE);
  assign hi      = r_hi;
  assign lo      = r_lo;
  assign rdata   = r_rdata;
  assign div0    = r_div0;
  assign illegal = r_illegal;

endmodule

// File: doc/hilo_muldiv.md
HILO_MULDIV -- requirements
Module: hilo_muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/HI/LO width; legal values are even and >= 4.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-004 SHALL have port start  input  1  request valid.
REQ-005 SHALL have port op  input  6  funct code: 011000 MULT, 011001 MULTU, 011100 MADD, 011101 MADDU, 011010 DIV, 011011 DIVU, 010001 MTHI, 010011 MTLO, 010000 MFHI, 010010 MFLO.
REQ-006 SHALL have port a  input  WIDTH  operand rs (dividend, multiplicand, MT source).
REQ-007 SHALL have port b  input  WIDTH  operand rt (divisor, multiplier).
REQ-008 SHALL have port busy  output  1  high whenever state != IDLE.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port hi, lo  output  WIDTH each  architectural HI/LO registers.
REQ-011 SHALL have port rdata  output  WIDTH  registered MFHI/MFLO result.
REQ-012 SHALL have port div0  output  1  one-cycle pulse, with done, for divide by zero.
REQ-013 SHALL have port illegal  output  1  one-cycle pulse for unrecognised op.

Function
REQ-014 Accept = start & ~busy, sampled at a rising edge; start while busy SHALL be ignored with no side effect, and upstream holds the request.
REQ-015 States SHALL be IDLE, CALC, FIX, DONE; done = 1 only in DONE; DONE -> IDLE unconditionally.
REQ-016 MULT/MULTU/MADD/MADDU/DIV/DIVU with nonzero divisor: IDLE -> CALC on accept, CALC for exactly WIDTH cycles (1 bit per cycle), then FIX for 1 cycle, then DONE; done SHALL rise WIDTH+2 cycles after the accept edge.
REQ-017 Operands SHALL be captured at accept; a/b changes afterwards SHALL not affect the result.
REQ-018 Multiply: iterative shift-add on magnitudes; signed ops take absolute values and negate the 2*WIDTH product in FIX when operand signs differ.
REQ-019 MULT/MULTU: {hi,lo} <= product in FIX; MADD/MADDU: {hi,lo} <= {hi,lo} + product, modulo 2^(2*WIDTH), carry out discarded.
REQ-020 Divide: restoring division on magnitudes; lo <= quotient, hi <= remainder; signed quotient negated if signs differ; remainder takes dividend sign.
REQ-021 Signed DIV of most-negative by -1 SHALL yield lo = most-negative, hi = 0, no flag.
REQ-022 DIV/DIVU with b = 0: IDLE -> DONE directly; hi <= a, lo <= all ones; div0 pulses with done one cycle after accept.
REQ-023 MTHI/MTLO: hi (resp. lo) <= a at the accept edge; IDLE -> DONE; done one cycle after accept.
REQ-024 MFHI/MFLO: rdata <= hi (resp. lo) at the accept edge; IDLE -> DONE; hi/lo unchanged.
REQ-025 hi/lo SHALL change only at the FIX edge, the accept edge of MT ops, or the divide-by-zero accept edge; during CALC they hold prior values.
REQ-026 Unrecognised op at accept: illegal pulses next cycle; state stays IDLE; no register change.

Reset
REQ-027 rst_n = 0 at a rising edge SHALL force state IDLE, hi = lo = rdata = 0, busy = done = div0 = illegal = 0, iteration counter 0.
REQ-028 Reset during CALC/FIX SHALL abandon the operation with no HI/LO update; the first accept after release behaves as from cold.

Verification (WIDTH = 32)
REQ-029 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done at accept+34, hi=0xFFFFFFFE, lo=0x00000001.
REQ-030 MULT a=-3, b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; then MTHI 0, MTLO 10, MADD a=4, b=-2 -> hi=0, lo=2.
REQ-031 DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=0 -> done and div0 at accept+1, hi=7, lo=0xFFFFFFFF.
REQ-032 start with MFLO held during CALC -> ignored until busy falls, then accepted; rdata = new lo one cycle later, done pulses once.
REQ-033 rst_n low for one cycle at accept+10 of MULTU -> hi=lo=0, busy=0, no done; op=111111 -> illegal pulse, busy stays 0.
